ir_uart_resp_parser: RTL and testbench
======================================

Name: ir_uart_resp_parser

Overview:
Receive-side companion to the IR sensor configuration controller. It deserialises the IR sensor's UART reply stream (115200 bps, 8N1) and parses response frames. It checks header, length, checksum and tail, then presents the command ID and payload of each good frame to the host logic with a single-cycle valid pulse. Bad frames produce a single-cycle error pulse with a code. Sits between the physical RxD pin and the sensor-bring-up sequencer, which uses it to confirm configure/save acknowledgements.

Parameters:
Freq_divider, 416, iClk cycles per UART bit (48 MHz / 115200).
MAX_LEN, 8, maximum payload bytes per frame (buffer depth, power of two).
TIMEOUT_CYC, 8320, idle cycles allowed between bytes inside a frame (about 20 bit times) before abort.

Ports:
iClk  in  1  system clock, 48 MHz.
iRst_N  in  1  asynchronous active-low reset.
iEn  in  1  parser enable; low forces parser to HUNT_H0 and suppresses all pulses.
iIR_UART_RxD  in  1  raw UART line from sensor, asynchronous, idle high.
iRd_Index  in  3  payload byte index for readback.
oRd_Data  out  8  committed payload byte [iRd_Index], combinational read of committed buffer.
oCmd  out  8  command ID of last good frame.
oLen  out  4  payload length of last good frame (0..MAX_LEN).
oFrame_Valid  out  1  one-cycle pulse: good frame committed.
oFrame_Err  out  1  one-cycle pulse: frame aborted.
oErr_Code  out  2  held cause of last error: 0 none, 1 checksum/tail, 2 stop-bit, 3 timeout/length overflow.

Behaviour:
- Reset is iRst_N, asynchronous, active-low; clock is iClk. All outputs reset to 0, committed buffer reset to 0x00, parser state HUNT_H0, rx state IDLE.
- Frame format: 0x55, 0xAA, CMD, LEN, LEN payload bytes, CHK, 0xF0. CHK = (CMD+LEN+payload bytes) mod 256, 8-bit wrap.
- Byte receiver:
  - RxD passes through a 2-flop synchroniser.
  - IDLE waits for a synchronised falling edge, then counts Freq_divider/2 cycles and re-samples. If the line is high, the edge is a glitch and the receiver returns to IDLE.
  - 8 data bits are sampled every Freq_divider cycles, LSB first.
  - Stop bit is sampled one bit time after the last data bit. High produces a one-cycle byte_valid. Low produces a one-cycle byte_ferr, and the receiver waits for the line to return high before re-entering IDLE.
- Parser states: HUNT_H0 -> HUNT_H1 -> CMD -> LEN -> PAYLOAD -> CHK -> TAIL.
  - HUNT_H0: 0x55 advances to HUNT_H1; any other byte stays.
  - HUNT_H1: 0xAA advances to CMD; 0x55 stays in HUNT_H1; any other byte returns to HUNT_H0.
  - CMD: store CMD in a work register and seed the running sum.
  - LEN: a value above MAX_LEN is an error, code 3. LEN=0 skips PAYLOAD and goes to CHK.
  - PAYLOAD: write bytes into the work buffer at a write index; go to CHK after the LEN-th byte.
  - CHK: compare the byte to the running sum. A mismatch is latched but still proceeds to TAIL, so the tail byte is consumed.
  - TAIL: 0xF0 with checksum OK commits. Otherwise error, code 1.
- Commit: on the cycle after the tail byte_valid:
  - copy work buffer to committed buffer;
  - oCmd and oLen load;
  - oFrame_Valid=1 for one cycle;
  - oErr_Code clears to 0.
  - Latency is 1 cycle from tail byte_valid.
- Error: oFrame_Err=1 for one cycle and oErr_Code loads. Parser returns to HUNT_H0. Committed outputs are unchanged.
- byte_ferr in any state other than HUNT_H0/HUNT_H1 is an error, code 2. In the hunt states it is silently ignored.
- Timeout: an inter-byte counter resets on each byte_valid and runs only outside the hunt states. Reaching TIMEOUT_CYC is an error, code 3.
- iEn low mid-frame: parser drops to HUNT_H0 with no pulse. The byte receiver keeps running.
- Simultaneous timeout and byte_valid on the same cycle: byte_valid wins.
- oFrame_Valid and oFrame_Err are never both high.
- iRd_Index >= oLen returns stale buffer contents; reading there is the host's responsibility.

Decomposition:
- Shared package: header/tail constants (0x55, 0xAA, 0xF0), error code constants, parser state encoding.
- One sub-module: ir_uart_rx_byte (synchroniser, bit timing, byte_valid/byte_ferr/data outputs). It is reusable by other UART links.

Test Plan:
- Good frame 55 AA 81 02 00 01 84 F0 at 416 cycles/bit: oFrame_Valid pulses once; oCmd=0x81, oLen=2; iRd_Index=0 gives 0x00 and iRd_Index=1 gives 0x01; oErr_Code=0.
- Same frame with CHK=0x85: oFrame_Err pulses after the tail byte with oErr_Code=1; oCmd/oLen keep their prior values.
- Stop bit forced low on the LEN byte: oFrame_Err with oErr_Code=2. The following good frame 55 AA 10 00 10 F0 is accepted: oCmd=0x10, oLen=0.
- Send 55 AA 20 01, then idle for 9000 cycles: oFrame_Err with oErr_Code=3 about 8320 cycles after the LEN byte. LEN=0x09 also gives code 3 immediately.
- Leading garbage 12 55 55 AA 81 00 81 F0: the frame is accepted, exercising the 0x55 re-sync. A 100-cycle low glitch on an idle line produces no byte.
- iRst_N asserted mid-payload, then released: all outputs 0 and no pulses. The next full good frame parses correctly.

Source files
------------

// File: rtl/ir_uart_resp_parser_pkg.sv
// ----------------------------------------------------------------------------
// ir_uart_resp_parser_pkg
// Shared constants for the IR sensor UART response path: frame delimiter
// bytes, error cause codes and the frame parser state encoding.
// ----------------------------------------------------------------------------
package ir_uart_resp_parser_pkg;

  // Frame delimiters: 0x55 0xAA CMD LEN payload... CHK 0xF0
  localparam logic [7:0] HDR0_BYTE = 8'h55;
  localparam logic [7:0] HDR1_BYTE = 8'hAA;
  localparam logic [7:0] TAIL_BYTE = 8'hF0;

  // Held error cause reported on oErr_Code
  localparam logic [1:0] ERR_NONE        = 2'd0;
  localparam logic [1:0] ERR_CHK_TAIL    = 2'd1;
  localparam logic [1:0] ERR_STOP        = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT_LEN = 2'd3;

  // Each state names the byte the parser expects next
  typedef enum logic [2:0] {
    P_HUNT_H0,
    P_HUNT_H1,
    P_CMD,
    P_LEN,
    P_PAYLOAD,
    P_CHK,
    P_TAIL
  } parser_state_e;

  // Hunt states are outside any frame: no timeout, framing errors ignored
  function automatic logic is_hunt(input parser_state_e s);
    return (s == P_HUNT_H0) || (s == P_HUNT_H1);
  endfunction

endpackage

// File: rtl/ir_uart_resp_parser_rx_byte.sv
// ----------------------------------------------------------------------------
// ir_uart_rx_byte
// Generic 8N1 UART byte receiver. The asynchronous line is synchronised,
// a falling edge starts a half-bit delay to the start-bit centre, then data
// bits are sampled once per bit time LSB first, followed by the stop bit.
//
// Ports:
//   iClk          system clock
//   iRst_N        asynchronous active-low reset
//   rxd_i         raw UART line, asynchronous, idle high
//   data_o        last received byte (valid while byte_valid_o is high)
//   byte_valid_o  one-cycle pulse: byte received with a good stop bit
//   byte_ferr_o   one-cycle pulse: stop bit sampled low (framing error)
// ----------------------------------------------------------------------------
module ir_uart_rx_byte #(
  parameter int Freq_divider = 416
) (
  input  logic       iClk,
  input  logic       iRst_N,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       byte_valid_o,
  output logic       byte_ferr_o
);

  localparam int CW = $clog2(Freq_divider);
  localparam logic [CW-1:0] BIT_LAST  = CW'(Freq_divider - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(Freq_divider / 2 - 1);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  rx_state_e      state_q;
  logic [1:0]     sync_q;
  logic           prev_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     bit_q;
  logic [7:0]     shift_q;
  logic           valid_q;
  logic           ferr_q;

  logic rxd_s;
  logic fall;

  assign rxd_s = sync_q[1];
  assign fall  = prev_q & ~rxd_s;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      // Synchroniser resets to the idle-high line level so no false edge
      sync_q  <= 2'b11;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], rxd_i};
      prev_q  <= rxd_s;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          if (fall) begin
            state_q <= RX_START;
            cnt_q   <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q <= '0;
            bit_q <= '0;
            // Still low at the start-bit centre: real start, else a glitch
            state_q <= rxd_s ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q   <= '0;
            shift_q <= {rxd_s, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rxd_s) begin
              valid_q <= 1'b1;
              state_q <= RX_IDLE;
            end else begin
              ferr_q  <= 1'b1;
              state_q <= RX_WAIT_HIGH;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RX_WAIT_HIGH: begin
          // A held-low line (break) must not be mistaken for a new start bit
          if (rxd_s) state_q <= RX_IDLE;
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

  assign data_o       = shift_q;
  assign byte_valid_o = valid_q;
  assign byte_ferr_o  = ferr_q;

endmodule

// File: rtl/ir_uart_resp_parser.sv
// ----------------------------------------------------------------------------
// ir_uart_resp_parser
// Deserialises the IR sensor UART reply stream and parses response frames
// 0x55 0xAA CMD LEN payload[LEN] CHK 0xF0, CHK = (CMD+LEN+payload) mod 256.
// Good frames are committed to a host-visible buffer with a one-cycle
// oFrame_Valid pulse; bad frames give a one-cycle oFrame_Err and a held code.
//
// Ports:
//   iClk, iRst_N   clock, asynchronous active-low reset
//   iEn            parser enable; low forces hunt state, no pulses
//   iIR_UART_RxD   raw UART line from the sensor
//   iRd_Index      committed payload byte index
//   oRd_Data       committed payload byte [iRd_Index] (combinational)
//   oCmd, oLen     command ID / payload length of the last good frame
//   oFrame_Valid   one-cycle pulse: good frame committed
//   oFrame_Err     one-cycle pulse: frame aborted
//   oErr_Code      held cause: 0 none, 1 chk/tail, 2 stop bit, 3 timeout/len
// ----------------------------------------------------------------------------
module ir_uart_resp_parser
  import ir_uart_resp_parser_pkg::*;
#(
  parameter int Freq_divider = 416,
  parameter int MAX_LEN      = 8,
  parameter int TIMEOUT_CYC  = 8320
) (
  input  logic                         iClk,
  input  logic                         iRst_N,
  input  logic                         iEn,
  input  logic                         iIR_UART_RxD,
  input  logic [$clog2(MAX_LEN)-1:0]   iRd_Index,
  output logic [7:0]                   oRd_Data,
  output logic [7:0]                   oCmd,
  output logic [$clog2(MAX_LEN+1)-1:0] oLen,
  output logic                         oFrame_Valid,
  output logic                         oFrame_Err,
  output logic [1:0]                   oErr_Code
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam int LW    = $clog2(MAX_LEN + 1);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0]    MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYC - 1);

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;

  ir_uart_rx_byte #(
    .Freq_divider (Freq_divider)
  ) u_rx (
    .iClk         (iClk),
    .iRst_N       (iRst_N),
    .rxd_i        (iIR_UART_RxD),
    .data_o       (rx_data),
    .byte_valid_o (rx_valid),
    .byte_ferr_o  (rx_ferr)
  );

  parser_state_e  state_q;
  logic [7:0]     cmd_w_q;
  logic [LW-1:0]  len_w_q;
  logic [LW-1:0]  idx_q;
  logic [7:0]     sum_q;
  logic           chk_bad_q;
  logic [TW-1:0]  to_cnt_q;
  logic [TW-1:0]  to_cnt_d;
  logic           timeout_hit;
  logic [7:0]     wbuf_q [MAX_LEN];
  logic [7:0]     cbuf_q [MAX_LEN];
  logic [7:0]     cmd_q;
  logic [LW-1:0]  len_q;
  logic           valid_q;
  logic           err_q;
  logic [1:0]     err_code_q;

  // Inter-byte timeout: cleared by every received byte and while hunting.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    to_cnt_d    = to_cnt_q + TW'(1);
    timeout_hit = 1'b0;
    if (!iEn || rx_valid || is_hunt(state_q)) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_LAST) begin
      timeout_hit = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_N) begin
    if (!iRst_N) begin
      state_q    <= P_HUNT_H0;
      cmd_w_q    <= '0;
      len_w_q    <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      chk_bad_q  <= 1'b0;
      to_cnt_q   <= '0;
      cmd_q      <= '0;
      len_q      <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      // NOTE: both buffers are reset: the committed one must read 0x00 after
      // reset, and clearing the work buffer keeps short frames from copying
      // unknown bytes into it.
      for (int i = 0; i < MAX_LEN; i++) begin
        wbuf_q[i] <= '0;
        cbuf_q[i] <= '0;
      end
    end else begin
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      to_cnt_q <= to_cnt_d;
      if (!iEn) begin
        state_q <= P_HUNT_H0;
      end else if (rx_valid) begin
        // A byte arriving on the timeout cycle takes priority over the abort
        case (state_q)
          P_HUNT_H0: begin
            if (rx_data == HDR0_BYTE) state_q <= P_HUNT_H1;
          end
          P_HUNT_H1: begin
            if (rx_data == HDR1_BYTE)      state_q <= P_CMD;
            else if (rx_data == HDR0_BYTE) state_q <= P_HUNT_H1;
            else                           state_q <= P_HUNT_H0;
          end
          P_CMD: begin
            cmd_w_q <= rx_data;
            sum_q   <= rx_data;
            state_q <= P_LEN;
          end
          P_LEN: begin
            if (rx_data > MAX_LEN_B) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_TIMEOUT_LEN;
              state_q    <= P_HUNT_H0;
            end else begin
              len_w_q <= rx_data[LW-1:0];
              sum_q   <= sum_q + rx_data;
              idx_q   <= '0;
              state_q <= (rx_data == 8'd0) ? P_CHK : P_PAYLOAD;
            end
          end
          P_PAYLOAD: begin
            wbuf_q[idx_q[IDX_W-1:0]] <= rx_data;
            sum_q <= sum_q + rx_data;
            idx_q <= idx_q + LW'(1);
            if ((idx_q + LW'(1)) == len_w_q) state_q <= P_CHK;
          end
          P_CHK: begin
            // Mismatch is only remembered so the tail byte is still consumed
            chk_bad_q <= (rx_data != sum_q);
            state_q   <= P_TAIL;
          end
          P_TAIL: begin
            if ((rx_data == TAIL_BYTE) && !chk_bad_q) begin
              for (int i = 0; i < MAX_LEN; i++) cbuf_q[i] <= wbuf_q[i];
              cmd_q      <= cmd_w_q;
              len_q      <= len_w_q;
              valid_q    <= 1'b1;
              err_code_q <= ERR_NONE;
            end else begin
              err_q      <= 1'b1;
              err_code_q <= ERR_CHK_TAIL;
            end
            state_q <= P_HUNT_H0;
          end
          default: state_q <= P_HUNT_H0;
        endcase
      end else if (rx_ferr && !is_hunt(state_q)) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_STOP;
        state_q    <= P_HUNT_H0;
      end else if (timeout_hit) begin
        err_q      <= 1'b1;
        err_code_q <= ERR_TIMEOUT_LEN;
        state_q    <= P_HUNT_H0;
      end
    end
  end

  assign oRd_Data     = cbuf_q[iRd_Index];
  assign oCmd         = cmd_q;
  assign oLen         = len_q;
  assign oFrame_Valid = valid_q;
  assign oFrame_Err   = err_q;
  assign oErr_Code    = err_code_q;

endmodule

// File: tb/tb_ir_uart_resp_parser.sv
// ----------------------------------------------------------------------------
// tb_ir_uart_resp_parser
// Serial-line stimulus for the IR UART response parser. Each frame's outcome
// is decided from the frame rules (header/length/checksum/tail) and pushed to
// a scoreboard queue; an independent monitor pops an entry on every DUT
// pulse and compares pulse kind, held outputs, payload readback and timing.
// The bit time is shortened so the whole run stays short.
// ----------------------------------------------------------------------------
module tb_ir_uart_resp_parser;

  localparam int BIT = 16;
  localparam int TO  = 20 * BIT;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       en     = 1'b1;
  logic       rxd    = 1'b1;
  logic [2:0] rd_idx = 3'd0;
  logic [7:0] rd_data;
  logic [7:0] cmd;
  logic [3:0] len;
  logic       f_valid;
  logic       f_err;
  logic [1:0] err_code;

  ir_uart_resp_parser #(
    .Freq_divider (BIT),
    .MAX_LEN      (8),
    .TIMEOUT_CYC  (TO)
  ) dut (
    .iClk         (clk),
    .iRst_N       (rst_n),
    .iEn          (en),
    .iIR_UART_RxD (rxd),
    .iRd_Index    (rd_idx),
    .oRd_Data     (rd_data),
    .oCmd         (cmd),
    .oLen         (len),
    .oFrame_Valid (f_valid),
    .oFrame_Err   (f_err),
    .oErr_Code    (err_code)
  );

  always #10 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] pl;
    longint      lo;
    longint      hi;
  } ev_t;

  ev_t sb[$];

  // Host-visible state the design should hold after each event
  logic [7:0]  m_cmd  = 8'h00;
  logic [3:0]  m_len  = 4'd0;
  logic [63:0] m_pl   = 64'h0;
  logic [1:0]  m_code = 2'd0;

  function automatic logic [7:0] frame_sum(input logic [7:0] c, input int n,
                                           input logic [63:0] pl);
    int s = int'(c) + n;
    for (int i = 0; i < n && i < 8; i++) s += int'(pl[8*i +: 8]);
    return 8'(s % 256);
  endfunction

  task automatic model_reset();
    m_cmd = 8'h00; m_len = 4'd0; m_pl = 64'h0; m_code = 2'd0;
  endtask

  task automatic push(input bit is_err, input longint lo, input longint hi);
    ev_t e;
    e.is_err = is_err; e.code = m_code; e.cmd = m_cmd; e.len = m_len;
    e.pl = m_pl; e.lo = lo; e.hi = hi;
    sb.push_back(e);
  endtask

  // Pulses expected after a byte that starts now: about 9.5 bit times later
  task automatic push_at_byte_end(input bit is_err);
    push(is_err, cyc + 9 * BIT, cyc + 10 * BIT);
  endtask

  // ---------------- line driver ----------------
  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rxd = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (BIT) @(negedge clk);
    end
    rxd = stop_ok;
    repeat (BIT) @(negedge clk);
    if (!stop_ok) idle(BIT);
    rxd = 1'b1;
  endtask

  task automatic tx(input logic [7:0] b);
    send_byte(b, 1'b1);
    idle($urandom_range(0, BIT));
  endtask

  task automatic tx_frame(input logic [7:0] c, input int n, input logic [63:0] pl,
                          input logic [7:0] chk_delta, input logic [7:0] tail);
    logic [7:0] chk;
    chk = frame_sum(c, n, pl) + chk_delta;
    tx(8'h55); tx(8'hAA); tx(c);
    if (n > 8) begin
      m_code = 2'd3;
      push_at_byte_end(1'b1);
      tx(8'(n));
      return;
    end
    tx(8'(n));
    for (int i = 0; i < n; i++) tx(pl[8*i +: 8]);
    tx(chk);
    if (chk_delta == 8'h00 && tail == 8'hF0) begin
      m_cmd = c; m_len = 4'(n); m_pl = pl; m_code = 2'd0;
      push_at_byte_end(1'b0);
    end else begin
      m_code = 2'd1;
      push_at_byte_end(1'b1);
    end
    tx(tail);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 * BIT && sb.size() != 0; i++) @(negedge clk);
    check(name, sb.size(), 0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (f_valid || f_err)) begin
        check("pulse_exclusive", longint'(f_valid && f_err), 0);
        if (sb.size() == 0) begin
          check("unexpected_pulse", longint'({f_valid, f_err}), 0);
        end else begin
          e = sb.pop_front();
          check("pulse_is_err", f_err, e.is_err);
          check("pulse_is_valid", f_valid, !e.is_err);
          check("err_code", err_code, e.code);
          check("cmd", cmd, e.cmd);
          check("len", len, e.len);
          check("pulse_time_in_window", longint'(cyc >= e.lo && cyc <= e.hi), 1);
          for (int i = 0; i < int'(e.len); i++) begin
            rd_idx = 3'(i);
            #1;
            check("rd_data", rd_data, e.pl[8*i +: 8]);
          end
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (5) @(negedge clk);
    check("reset_cmd", cmd, 0);
    check("reset_len", len, 0);
    check("reset_err_code", err_code, 0);
    check("reset_valid", f_valid, 0);
    check("reset_err", f_err, 0);
    check("reset_rd_data", rd_data, 0);
    rst_n = 1'b1;
    model_reset();
    idle(2 * BIT);

    // Good frame 55 AA 81 02 00 01 84 F0
    tx_frame(8'h81, 2, 64'h0100, 8'h00, 8'hF0);
    wait_drain("drain_good");

    // Same frame with CHK=0x85
    tx_frame(8'h81, 2, 64'h0100, 8'h01, 8'hF0);
    wait_drain("drain_bad_chk");

    // Stop bit low on the LEN byte, then a zero-length good frame
    tx(8'h55); tx(8'hAA); tx(8'h81);
    m_code = 2'd2;
    push_at_byte_end(1'b1);
    send_byte(8'h02, 1'b0);
    idle(BIT);
    tx_frame(8'h10, 0, 64'h0, 8'h00, 8'hF0);
    wait_drain("drain_stop_bit");

    // Inter-byte timeout after the LEN byte
    tx(8'h55); tx(8'hAA); tx(8'h20);
    send_byte(8'h01, 1'b1);
    m_code = 2'd3;
    push(1'b1, cyc + TO - BIT, cyc + TO + BIT);
    idle(TO + 200);
    wait_drain("drain_timeout");

    // Length overflow
    tx_frame(8'h20, 9, 64'h0, 8'h00, 8'hF0);
    wait_drain("drain_len_overflow");

    // Leading garbage and a repeated 0x55 before the header
    tx(8'h12); tx(8'h55);
    tx_frame(8'h81, 0, 64'h0, 8'h00, 8'hF0);
    wait_drain("drain_resync");

    // Short low glitch inside a frame must not become a byte
    tx(8'h55); tx(8'hAA); tx(8'h81);
    idle(3);
    rxd = 1'b0;
    repeat (BIT / 2 - 3) @(negedge clk);
    idle(2 * BIT);
    tx(8'h00); tx(8'h81);
    m_cmd = 8'h81; m_len = 4'd0; m_code = 2'd0;
    push_at_byte_end(1'b0);
    tx(8'hF0);
    wait_drain("drain_glitch");

    // Enable dropped mid-payload: silent abort, no timeout afterwards
    tx(8'h55); tx(8'hAA); tx(8'h30); tx(8'h02); tx(8'hAA);
    en = 1'b0;
    idle(50);
    en = 1'b1;
    idle(TO + 50);
    tx_frame(8'h33, 3, 64'h00C0FFEE, 8'h00, 8'hF0);
    wait_drain("drain_enable");

    // Reset mid-payload
    tx(8'h55); tx(8'hAA); tx(8'h81); tx(8'h03); tx(8'h5A);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("midreset_cmd", cmd, 0);
    check("midreset_len", len, 0);
    check("midreset_err_code", err_code, 0);
    check("midreset_valid", f_valid, 0);
    check("midreset_err", f_err, 0);
    check("midreset_rd_data", rd_data, 0);
    model_reset();
    rst_n = 1'b1;
    idle(2 * BIT);
    check("post_reset_cmd", cmd, 0);
    tx_frame(8'h42, 3, 64'h00A5_5A0F, 8'h00, 8'hF0);
    wait_drain("drain_post_reset");

    // Randomised frames: good, bad checksum, bad tail, oversize length
    for (int f = 0; f < 14; f++) begin
      logic [7:0]  c;
      logic [63:0] pl;
      logic [7:0]  delta;
      logic [7:0]  tail;
      int          n;
      int          r;
      c     = 8'($urandom);
      pl    = {$urandom, $urandom};
      n     = $urandom_range(0, 8);
      r     = $urandom_range(0, 7);
      delta = 8'h00;
      tail  = 8'hF0;
      if (r == 0) delta = 8'($urandom_range(1, 255));
      if (r == 1) begin
        tail = 8'($urandom_range(0, 254));
        if (tail == 8'hF0) tail = 8'hFF;
      end
      if (r == 2) n = $urandom_range(9, 15);
      tx_frame(c, n, pl, delta, tail);
      idle($urandom_range(0, 2 * BIT));
    end
    wait_drain("drain_random");

    // Quiet line: nothing further may be reported
    idle(2 * TO);
    check("scoreboard_empty_at_end", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
